move_lifo: RTL and testbench

Parametrised LIFO storage for move words produced by the RX discovery phase and drained by the top-level FSM through the arbiters. It generalises the single-width, fixed-depth move stack. Additions:
- configurable width and depth;
- a registered pop handshake;
- simultaneous push/pop (replace-top);
- full and occupancy outputs;
- sticky overflow/underflow flags;
- a synchronous flush.

---
 rtl/move_lifo_pkg.sv | 13 +
 rtl/move_lifo_stack_mem.sv | 22 ++
 rtl/move_lifo.sv | 149 ++++++++++++++
 tb/tb_move_lifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/move_lifo_pkg.sv
// Shared types and defaults for the move LIFO.
package move_lifo_pkg;

  localparam int MOVE_W = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [MOVE_W-1:0] move_t;

endpackage

// File: rtl/move_lifo_stack_mem.sv
// Single-port synchronous RAM, read-first, one-cycle read latency.
module stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             wren,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Read returns the pre-write contents when addr is written in the same cycle.
  always_ff @(posedge clk) begin
    rdata <= mem_q[addr];
    if (wren) mem_q[addr] <= wdata;
  end

endmodule

// File: rtl/move_lifo.sv
// Parametrised move-word LIFO with registered pop output, replace-top and sticky flags.
// Optional MOVE_LIFO_CLEAR_EN adds an INIT state that zeroes the RAM after reset.
module move_lifo
  import move_lifo_pkg::*;
#(
  parameter int WIDTH = MOVE_W,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] move_in,
  input  logic             pop,
  input  logic             flush,
  output logic             ready,
  output logic [WIDTH-1:0] move_out,
  output logic             out_valid,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_pend_q, rd_pend_d;
  logic [WIDTH-1:0] move_out_q;
  logic             out_valid_q;

  logic [AW-1:0]    addr;
  logic             wren;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

`ifdef MOVE_LIFO_CLEAR_EN
  state_e        state_q, state_d;
  logic [AW-1:0] init_addr_q, init_addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == INIT) begin
      init_addr_d = init_addr_q + AW'(1);
      if (init_addr_q == AW'(DEPTH - 1)) state_d = RUN;
    end
  end

  assign ready = (state_q == RUN);
`else
  assign ready = 1'b1;
`endif

  // Operation decode: flush wins, then replace-top, push, pop; guards keep count in range.
  always_comb begin
    count_d   = count_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    rd_pend_d = 1'b0;
    addr      = AW'(count_q);
    wren      = 1'b0;
    wdata     = move_in;
`ifdef MOVE_LIFO_CLEAR_EN
    if (state_q == INIT) begin
      addr  = init_addr_q;
      wren  = 1'b1;
      wdata = '0;
    end else
`endif
    if (flush) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (push && pop && (count_q != '0)) begin
      addr      = AW'(count_q - CW'(1));
      wren      = 1'b1;
      rd_pend_d = 1'b1;
    end else if (push) begin
      if (pop) udf_d = 1'b1;
      if (count_q == FULL_CNT) begin
        ovf_d = 1'b1;
      end else begin
        wren    = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (count_q == '0) begin
        udf_d = 1'b1;
      end else begin
        addr      = AW'(count_q - CW'(1));
        rd_pend_d = 1'b1;
        count_d   = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      move_out_q  <= '0;
    end else begin
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= rd_pend_q;
      if (rd_pend_q) move_out_q <= rdata;
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .addr  (addr),
    .wren  (wren),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign move_out  = move_out_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_move_lifo.sv
// Self-checking bench for move_lifo: directed scenarios plus random traffic against a queue model.
module tb_move_lifo;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  move_in = '0;
  logic          ready;
  logic [W-1:0]  move_out;
  logic          out_valid;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  move_lifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .move_in   (move_in),
    .pop       (pop),
    .flush     (flush),
    .ready     (ready),
    .move_out  (move_out),
    .out_valid (out_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: stack contents plus output/flag state.
  logic [W-1:0] stk[$];
  bit           m_ovf, m_udf, m_vld, m_pend;
  logic [W-1:0] m_out, m_pval;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".ready"},     32'(ready),     32'(1));
    chk({ctx, ".count"},     32'(count),     32'(stk.size()));
    chk({ctx, ".empty"},     32'(empty),     32'(stk.size() == 0));
    chk({ctx, ".full"},      32'(full),      32'(stk.size() == D));
    chk({ctx, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({ctx, ".underflow"}, 32'(underflow), 32'(m_udf));
    chk({ctx, ".out_valid"}, 32'(out_valid), 32'(m_vld));
    chk({ctx, ".move_out"},  32'(move_out),  32'(m_out));
  endtask

  // Called just after a falling edge; applies one cycle of inputs and checks the result.
  task automatic step(input string ctx, input bit p, input bit po, input bit f,
                      input logic [W-1:0] d);
    push = p; pop = po; flush = f; move_in = d;
    @(posedge clk);
    m_vld = m_pend;
    if (m_pend) m_out = m_pval;
    m_pend = 1'b0;
    if (f) begin
      stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (p && po && stk.size() > 0) begin
      m_pval = stk[stk.size() - 1];
      stk[stk.size() - 1] = d;
      m_pend = 1'b1;
    end else if (p) begin
      if (po) m_udf = 1'b1;
      if (stk.size() == D) m_ovf = 1'b1;
      else stk.push_back(d);
    end else if (po) begin
      if (stk.size() == 0) m_udf = 1'b1;
      else begin
        m_pval = stk.pop_back();
        m_pend = 1'b1;
      end
    end
    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    int n;
    n = 0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    stk.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0; m_pend = 1'b0; m_out = '0;
`ifdef MOVE_LIFO_CLEAR_EN
    chk({ctx, ".rst_ready"}, 32'(ready), 32'(0));
`else
    chk({ctx, ".rst_ready"}, 32'(ready), 32'(1));
`endif
    chk({ctx, ".rst_count"},     32'(count),     32'(0));
    chk({ctx, ".rst_empty"},     32'(empty),     32'(1));
    chk({ctx, ".rst_full"},      32'(full),      32'(0));
    chk({ctx, ".rst_overflow"},  32'(overflow),  32'(0));
    chk({ctx, ".rst_underflow"}, 32'(underflow), 32'(0));
    chk({ctx, ".rst_out_valid"}, 32'(out_valid), 32'(0));
    chk({ctx, ".rst_move_out"},  32'(move_out),  32'(0));
    rst = 1'b0;
    while (!ready && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
`ifdef MOVE_LIFO_CLEAR_EN
    chk({ctx, ".init_cycles"}, 32'(n), 32'(D));
`else
    chk({ctx, ".init_cycles"}, 32'(n), 32'(0));
`endif
    check_all({ctx, ".post_init"});
  endtask

  initial begin
    logic [W-1:0] held;
    int           pp;
    bit           rp, rpo, rf;

    @(negedge clk);
    do_reset("reset");

    // LIFO ordering with back-to-back pops
    for (int k = 1; k <= 3; k++) step("push3", 1'b1, 1'b0, 1'b0, W'(k));
    step("pop3", 1'b0, 1'b1, 1'b0, '0);
    step("pop3", 1'b0, 1'b1, 1'b0, '0);
    chk("order.first", 32'(move_out), 32'h3);
    step("pop3", 1'b0, 1'b1, 1'b0, '0);
    chk("order.second", 32'(move_out), 32'h2);
    step("idle", 1'b0, 1'b0, 1'b0, '0);
    chk("order.third", 32'(move_out), 32'h1);
    chk("order.valid", 32'(out_valid), 32'(1));
    chk("order.empty", 32'(empty), 32'(1));

    // Fill, then overflow
    for (int k = 1; k <= D; k++) step("fill", 1'b1, 1'b0, 1'b0, W'(k));
    step("ovf", 1'b1, 1'b0, 1'b0, 16'hBEEF);
    chk("ovf.full", 32'(full), 32'(1));
    chk("ovf.flag", 32'(overflow), 32'(1));
    chk("ovf.count", 32'(count), 32'(16));
    step("ovf_pop", 1'b0, 1'b1, 1'b0, '0);
    step("idle", 1'b0, 1'b0, 1'b0, '0);
    chk("ovf.top", 32'(move_out), 32'h10);

    // Drain, then underflow and flush
    for (int k = 0; k < D - 1; k++) step("drain", 1'b0, 1'b1, 1'b0, '0);
    step("idle", 1'b0, 1'b0, 1'b0, '0);
    held = move_out;
    step("udf", 1'b0, 1'b1, 1'b0, '0);
    step("idle", 1'b0, 1'b0, 1'b0, '0);
    chk("udf.flag", 32'(underflow), 32'(1));
    chk("udf.valid", 32'(out_valid), 32'(0));
    chk("udf.hold", 32'(move_out), 32'(held));
    step("flush", 1'b0, 1'b0, 1'b1, '0);
    chk("flush.udf", 32'(underflow), 32'(0));

    // Replace-top on a full stack
    for (int k = 1; k <= D; k++) step("fill2", 1'b1, 1'b0, 1'b0, W'(k));
    step("replace", 1'b1, 1'b1, 1'b0, 16'hAAAA);
    step("idle", 1'b0, 1'b0, 1'b0, '0);
    chk("replace.old_top", 32'(move_out), 32'h10);
    chk("replace.count", 32'(count), 32'(16));
    chk("replace.no_ovf", 32'(overflow), 32'(0));
    step("replace_pop", 1'b0, 1'b1, 1'b0, '0);
    step("idle", 1'b0, 1'b0, 1'b0, '0);
    chk("replace.new_top", 32'(move_out), 32'hAAAA);

    // Random traffic, alternating push-heavy and pop-heavy phases
    for (int i = 0; i < 600; i++) begin
      pp  = ((i / 64) % 2 == 0) ? 70 : 30;
      rp  = ($urandom_range(0, 99) < pp);
      rpo = ($urandom_range(0, 99) < 45);
      rf  = ($urandom_range(0, 79) == 0);
      step("rand", rp, rpo, rf, W'($urandom));
    end

    // Reset mid-stream
    step("pre_rst", 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 5; k++) step("pre_rst", 1'b1, 1'b0, 1'b0, W'($urandom));
    chk("midrst.count5", 32'(count), 32'(5));
    do_reset("midrst");
    step("post_rst", 1'b1, 1'b0, 1'b0, 16'h1234);
    step("post_rst", 1'b0, 1'b1, 1'b0, '0);
    step("idle", 1'b0, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
